// File: rtl/sw_sequence_decoder.sv
// Switcher sequence decoder: finds SW_CLK / SW_FRAME rising edges in the 4-sample
// deserialized bus, tracks frame and row position, and raises sticky sequence errors.
module sw_sequence_decoder #(
    parameter int N_ROWS = 192,
    parameter int ROW_W  = 8
) (
    input  logic             CLK_80,
    input  logic             RESET_N,
    input  logic [15:0]      SW_DES,
    input  logic             ENABLE,
    input  logic             CLR_ERR,
    output logic             ROW_STB,
    output logic [ROW_W-1:0] ROW_ADDR,
    output logic [1:0]       ROW_PHASE,
    output logic             FRAME_STB,
    output logic             FRAME_DONE,
    output logic [15:0]      FRAME_CNT,
    output logic             IN_FRAME,
    output logic             GATE_ON,
    output logic             CLEAR_ON,
    output logic             ERR_SHORT,
    output logic             ERR_LONG,
    output logic             ERR_MULTI
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SEARCH   = 2'd1;
    localparam logic [1:0] ST_IN_FRAME = 2'd2;
    localparam logic [1:0] ST_POST     = 2'd3;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N_ROWS - 1);
    localparam logic [ROW_W-1:0] ROW_ZERO = {ROW_W{1'b0}};

    // Rising edge per sample; sample 0 is compared against the last sample of the previous cycle.
    function automatic logic [3:0] rise_vec(input logic [3:0] s, input logic prev);
        rise_vec = s & ~{s[2:0], prev};
    endfunction

    function automatic logic [1:0] first_idx(input logic [3:0] v);
        if (v[0]) begin
            first_idx = 2'd0;
        end else if (v[1]) begin
            first_idx = 2'd1;
        end else if (v[2]) begin
            first_idx = 2'd2;
        end else if (v[3]) begin
            first_idx = 2'd3;
        end else begin
            first_idx = 2'd0;
        end
    endfunction

    logic [1:0]       state_r;
    logic [ROW_W-1:0] row_cnt_r;
    logic             prev_clk_r;
    logic             prev_frame_r;

    logic [3:0]       clk_rise_s;
    logic [3:0]       frame_rise_s;
    logic             clk_edge_s;
    logic             clk_multi_s;
    logic [1:0]       clk_phase_s;
    logic             frame_edge_s;
    logic             unused_des_s;

    logic [1:0]       state_nxt_s;
    logic [ROW_W-1:0] row_cnt_nxt_s;
    logic [15:0]      fcnt_nxt_s;
    logic [ROW_W-1:0] row_addr_nxt_s;
    logic [1:0]       row_phase_nxt_s;
    logic             row_stb_s;
    logic             frame_stb_s;
    logic             frame_done_s;
    logic             set_short_s;
    logic             set_long_s;
    logic             set_multi_s;

    assign clk_rise_s   = rise_vec(SW_DES[3:0], prev_clk_r);
    assign frame_rise_s = rise_vec(SW_DES[7:4], prev_frame_r);
    assign clk_edge_s   = |clk_rise_s;
    assign clk_multi_s  = (clk_rise_s & (clk_rise_s - 4'd1)) != 4'd0;
    assign clk_phase_s  = first_idx(clk_rise_s);
    assign frame_edge_s = |frame_rise_s;
    assign unused_des_s = ^{SW_DES[14:12], SW_DES[10:8]};

    // Sequencer next-state: a frame edge always wins over a clock edge in the same cycle.
    always_comb begin
        state_nxt_s     = state_r;
        row_cnt_nxt_s   = row_cnt_r;
        fcnt_nxt_s      = FRAME_CNT;
        row_addr_nxt_s  = ROW_ADDR;
        row_phase_nxt_s = ROW_PHASE;
        row_stb_s       = 1'b0;
        frame_stb_s     = 1'b0;
        frame_done_s    = 1'b0;
        set_short_s     = 1'b0;
        set_long_s      = 1'b0;
        set_multi_s     = 1'b0;
        if (!ENABLE) begin
            state_nxt_s   = ST_IDLE;
            row_cnt_nxt_s = ROW_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_SEARCH;
                end
                ST_SEARCH, ST_POST: begin
                    if (frame_edge_s) begin
                        state_nxt_s   = ST_IN_FRAME;
                        frame_stb_s   = 1'b1;
                        fcnt_nxt_s    = FRAME_CNT + 16'd1;
                        row_cnt_nxt_s = ROW_ZERO;
                    end else if (clk_edge_s && (state_r == ST_POST)) begin
                        set_long_s = 1'b1;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                ST_IN_FRAME: begin
                    if (frame_edge_s) begin
                        set_short_s   = (row_cnt_r != ROW_ZERO);
                        frame_stb_s   = 1'b1;
                        fcnt_nxt_s    = FRAME_CNT + 16'd1;
                        row_cnt_nxt_s = ROW_ZERO;
                    end else if (clk_edge_s) begin
                        // Multi-edge error is only meaningful where a row is actually counted.
                        row_stb_s       = 1'b1;
                        row_addr_nxt_s  = row_cnt_r;
                        row_phase_nxt_s = clk_phase_s;
                        set_multi_s     = clk_multi_s;
                        if (row_cnt_r == LAST_ROW) begin
                            frame_done_s  = 1'b1;
                            state_nxt_s   = ST_POST;
                            row_cnt_nxt_s = ROW_ZERO;
                        end else begin
                            row_cnt_nxt_s = row_cnt_r + ROW_W'(1);
                        end
                    end else begin
                        state_nxt_s = ST_IN_FRAME;
                    end
                end
                default: begin
                    state_nxt_s   = ST_IDLE;
                    row_cnt_nxt_s = ROW_ZERO;
                end
            endcase
        end
    end

    // State, counters and all outputs registered; error set beats same-cycle clear.
    always_ff @(posedge CLK_80 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r      <= ST_IDLE;
            row_cnt_r    <= ROW_ZERO;
            prev_clk_r   <= 1'b0;
            prev_frame_r <= 1'b0;
            ROW_STB      <= 1'b0;
            ROW_ADDR     <= ROW_ZERO;
            ROW_PHASE    <= 2'd0;
            FRAME_STB    <= 1'b0;
            FRAME_DONE   <= 1'b0;
            FRAME_CNT    <= 16'd0;
            IN_FRAME     <= 1'b0;
            GATE_ON      <= 1'b0;
            CLEAR_ON     <= 1'b0;
            ERR_SHORT    <= 1'b0;
            ERR_LONG     <= 1'b0;
            ERR_MULTI    <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            row_cnt_r    <= row_cnt_nxt_s;
            prev_clk_r   <= SW_DES[3];
            prev_frame_r <= SW_DES[7];
            ROW_STB      <= row_stb_s;
            ROW_ADDR     <= row_addr_nxt_s;
            ROW_PHASE    <= row_phase_nxt_s;
            FRAME_STB    <= frame_stb_s;
            FRAME_DONE   <= frame_done_s;
            FRAME_CNT    <= fcnt_nxt_s;
            IN_FRAME     <= (state_nxt_s == ST_IN_FRAME);
            GATE_ON      <= SW_DES[15];
            CLEAR_ON     <= SW_DES[11];
            ERR_SHORT    <= (ERR_SHORT & ~CLR_ERR) | set_short_s;
            ERR_LONG     <= (ERR_LONG  & ~CLR_ERR) | set_long_s;
            ERR_MULTI    <= (ERR_MULTI & ~CLR_ERR) | set_multi_s;
        end
    end

endmodule

// File: tb/tb_sw_sequence_decoder.sv
// Randomized + directed bench for sw_sequence_decoder, checked every cycle against a
// frame/row behavioural model (N_ROWS=4).
module tb_sw_sequence_decoder;

    localparam int NR = 4;
    localparam int RW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          clr_err = 1'b0;
    logic [15:0]   sw_des = 16'd0;

    logic          row_stb;
    logic [RW-1:0] row_addr;
    logic [1:0]    row_phase;
    logic          frame_stb;
    logic          frame_done;
    logic [15:0]   frame_cnt;
    logic          in_frame;
    logic          gate_on;
    logic          clear_on;
    logic          err_short;
    logic          err_long;
    logic          err_multi;

    sw_sequence_decoder #(.N_ROWS(NR), .ROW_W(RW)) dut (
        .CLK_80(clk), .RESET_N(rst_n), .SW_DES(sw_des), .ENABLE(enable), .CLR_ERR(clr_err),
        .ROW_STB(row_stb), .ROW_ADDR(row_addr), .ROW_PHASE(row_phase),
        .FRAME_STB(frame_stb), .FRAME_DONE(frame_done), .FRAME_CNT(frame_cnt),
        .IN_FRAME(in_frame), .GATE_ON(gate_on), .CLEAR_ON(clear_on),
        .ERR_SHORT(err_short), .ERR_LONG(err_long), .ERR_MULTI(err_multi)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: mode 0 idle, 1 searching, 2 inside frame, 3 frame completed.
    int          m_mode;
    int          m_rows;
    logic [15:0] m_fcnt;
    logic        m_pc, m_pf;
    logic        e_row_stb, e_frame_stb, e_frame_done, e_in_frame, e_gate, e_clear;
    logic        e_short, e_long, e_multi;
    int          e_row_addr, e_row_phase;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_rows = 0; m_fcnt = 16'd0; m_pc = 1'b0; m_pf = 1'b0;
        e_row_stb = 1'b0; e_frame_stb = 1'b0; e_frame_done = 1'b0; e_in_frame = 1'b0;
        e_gate = 1'b0; e_clear = 1'b0; e_short = 1'b0; e_long = 1'b0; e_multi = 1'b0;
        e_row_addr = 0; e_row_phase = 0;
    endtask

    task automatic model_step(input logic en, input logic clr, input logic [15:0] des);
        logic [4:0] cx, fx;
        int n_clk, first;
        bit f_edge, s_short, s_long, s_multi;
        cx = {des[3:0], m_pc};
        fx = {des[7:4], m_pf};
        n_clk = 0; first = 0; f_edge = 0;
        for (int i = 0; i < 4; i++) begin
            if (cx[i+1] && !cx[i]) begin
                if (n_clk == 0) first = i;
                n_clk++;
            end
            if (fx[i+1] && !fx[i]) f_edge = 1;
        end
        s_short = 0; s_long = 0; s_multi = 0;
        e_row_stb = 1'b0; e_frame_stb = 1'b0; e_frame_done = 1'b0;
        if (!en) begin
            m_mode = 0; m_rows = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (f_edge) begin
            if (m_mode == 2 && m_rows != 0) s_short = 1;
            m_mode = 2; m_rows = 0; m_fcnt = m_fcnt + 16'd1; e_frame_stb = 1'b1;
        end else if (n_clk > 0 && m_mode == 3) begin
            s_long = 1;
        end else if (n_clk > 0 && m_mode == 2) begin
            e_row_stb = 1'b1; e_row_addr = m_rows; e_row_phase = first;
            if (n_clk > 1) s_multi = 1;
            if (m_rows == NR - 1) begin
                e_frame_done = 1'b1; m_mode = 3;
            end
            m_rows++;
        end
        e_short = (e_short && !clr) || s_short;
        e_long  = (e_long  && !clr) || s_long;
        e_multi = (e_multi && !clr) || s_multi;
        m_pc = des[3]; m_pf = des[7];
        e_gate = des[15]; e_clear = des[11];
        e_in_frame = (m_mode == 2);
    endtask

    task automatic compare();
        chk("row_stb", row_stb, e_row_stb);
        chk("row_addr", row_addr, e_row_addr);
        chk("row_phase", row_phase, e_row_phase);
        chk("frame_stb", frame_stb, e_frame_stb);
        chk("frame_done", frame_done, e_frame_done);
        chk("frame_cnt", frame_cnt, m_fcnt);
        chk("in_frame", in_frame, e_in_frame);
        chk("gate_on", gate_on, e_gate);
        chk("clear_on", clear_on, e_clear);
        chk("err_short", err_short, e_short);
        chk("err_long", err_long, e_long);
        chk("err_multi", err_multi, e_multi);
    endtask

    task automatic step(input logic en, input logic clr, input logic [15:0] des);
        @(negedge clk);
        enable = en; clr_err = clr; sw_des = des;
        model_step(en, clr, des);
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic zero_check(input string tag);
        chk({tag, "_row_stb"}, row_stb, 32'd0);
        chk({tag, "_row_addr"}, row_addr, 32'd0);
        chk({tag, "_row_phase"}, row_phase, 32'd0);
        chk({tag, "_frame_stb"}, frame_stb, 32'd0);
        chk({tag, "_frame_done"}, frame_done, 32'd0);
        chk({tag, "_frame_cnt"}, frame_cnt, 32'd0);
        chk({tag, "_in_frame"}, in_frame, 32'd0);
        chk({tag, "_gate_on"}, gate_on, 32'd0);
        chk({tag, "_clear_on"}, clear_on, 32'd0);
        chk({tag, "_err_short"}, err_short, 32'd0);
        chk({tag, "_err_long"}, err_long, 32'd0);
        chk({tag, "_err_multi"}, err_multi, 32'd0);
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        zero_check(tag);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] r;
        logic [15:0] des;
        int guard;
        model_reset();
        #12;
        zero_check("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Frame edge at phase 2, then four rows
        step(1'b1, 1'b0, 16'h0000);
        step(1'b1, 1'b0, 16'h0040);
        chk("t1_frame_stb", frame_stb, 32'd1);
        chk("t1_frame_cnt", frame_cnt, 32'd1);
        chk("t1_in_frame", in_frame, 32'd1);
        step(1'b1, 1'b0, 16'h000C);
        chk("t2_row_stb", row_stb, 32'd1);
        chk("t2_row0_addr", row_addr, 32'd0);
        chk("t2_phase2", row_phase, 32'd2);
        chk("t2_no_multi", err_multi, 32'd0);
        step(1'b1, 1'b0, 16'h0000);
        step(1'b1, 1'b0, 16'h0005);
        chk("t2_multi_stb", row_stb, 32'd1);
        chk("t2_row1_addr", row_addr, 32'd1);
        chk("t2_multi_phase", row_phase, 32'd0);
        chk("t2_err_multi", err_multi, 32'd1);
        step(1'b1, 1'b0, 16'h0001);
        chk("t1_row2_addr", row_addr, 32'd2);
        step(1'b1, 1'b0, 16'h0002);
        chk("t1_row3_addr", row_addr, 32'd3);
        chk("t1_row3_phase", row_phase, 32'd1);
        chk("t1_frame_done", frame_done, 32'd1);
        chk("t1_post_in_frame", in_frame, 32'd0);

        // Extra clock after the frame, then clear
        step(1'b1, 1'b0, 16'h0001);
        chk("t4_err_long", err_long, 32'd1);
        chk("t4_no_row_stb", row_stb, 32'd0);
        step(1'b1, 1'b1, 16'h0000);
        chk("t4_cleared_long", err_long, 32'd0);
        chk("t4_cleared_multi", err_multi, 32'd0);

        // Short frame
        step(1'b1, 1'b0, 16'h0040);
        step(1'b1, 1'b0, 16'h0001);
        step(1'b1, 1'b0, 16'h0001);
        step(1'b1, 1'b0, 16'h0040);
        chk("t3_err_short", err_short, 32'd1);
        chk("t3_frame_stb", frame_stb, 32'd1);
        chk("t3_frame_cnt", frame_cnt, 32'd3);
        step(1'b1, 1'b0, 16'h0001);
        chk("t3_restart_addr", row_addr, 32'd0);

        // Frame and clock edges in the same cycle
        step(1'b1, 1'b0, 16'h0041);
        chk("t5_frame_stb", frame_stb, 32'd1);
        chk("t5_no_row_stb", row_stb, 32'd0);
        chk("t5_frame_cnt", frame_cnt, 32'd4);
        step(1'b1, 1'b0, 16'h0001);
        chk("t5_next_addr", row_addr, 32'd0);
        chk("t5_next_stb", row_stb, 32'd1);

        // Disable mid-frame
        step(1'b0, 1'b0, 16'h0001);
        chk("dis_in_frame", in_frame, 32'd0);
        chk("dis_no_stb", row_stb, 32'd0);
        step(1'b0, 1'b0, 16'hFF40);
        chk("dis_no_frame", frame_stb, 32'd0);
        chk("dis_cnt_held", frame_cnt, 32'd4);
        chk("dis_gate", gate_on, 32'd1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            r = $urandom;
            des = r[15:0];
            if (r[19:16] != 4'd0) des[7:4] = 4'h0;
            if ($urandom_range(0, 599) == 0) async_reset("rnd_rst");
            step(r[24:20] != 5'd0, r[30:25] == 6'd0, des);
        end

        // Frame counter wrap
        guard = 0;
        while (m_fcnt != 16'hFFFF && guard < 70000) begin
            step(1'b1, 1'b0, 16'h0040);
            guard++;
        end
        chk("t6_cnt_ffff", frame_cnt, 32'h0000FFFF);
        step(1'b1, 1'b0, 16'h0040);
        chk("t6_cnt_wrap", frame_cnt, 32'd0);
        chk("t6_wrap_stb", frame_stb, 32'd1);

        // Async reset mid-frame
        step(1'b1, 1'b0, 16'h0801);
        chk("t6_pre_rst_stb", row_stb, 32'd1);
        async_reset("t6_rst");
        step(1'b1, 1'b0, 16'h0000);
        chk("t6_after_rst_in_frame", in_frame, 32'd0);
        step(1'b1, 1'b0, 16'h0040);
        chk("t6_after_rst_cnt", frame_cnt, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
